// File: rtl/cache_pkg.sv
// Shared types and helpers for the N-way cache controller.
// Holds the FSM state encoding, write policies and way-index helpers.
package cache_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOOKUP,
    S_WB_REQ,
    S_WB_DATA,
    S_RF_REQ,
    S_RF_DATA,
    S_WT_REQ,
    S_WT_DATA,
    S_FINISH
  } ctrl_state_t;

  localparam int POLICY_WB = 0;
  localparam int POLICY_WT = 1;

  // Widest way vector the helpers accept.
  localparam int MAX_WAYS = 64;

  // Index of the set bit of a one-hot vector (0 for all-zero).
  function automatic int onehot_to_idx(
    input logic [MAX_WAYS-1:0] v
  );
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_WAYS; i++) begin
      if (v[i]) idx = idx | i;
    end
    return idx;
  endfunction

  // Lowest index below n whose bit is clear (0 if none).
  function automatic int first_zero_idx(
    input logic [MAX_WAYS-1:0] v,
    input int                  n
  );
    int   idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    for (int i = 0; i < MAX_WAYS; i++) begin
      if (i < n && !found && !v[i]) begin
        idx   = i;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/cache_ctrl_nway_if.sv
// CPU, tag/data array and memory strobes of the cache controller.
// slave = controller view, master = environment view.
interface cache_ctrl_nway_if #(
  parameter int WAYS       = 4,
  parameter int LINE_WORDS = 4
);
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

  logic              req_valid;
  logic              req_we;
  logic              req_ready;
  logic              tag_rd_en;
  logic [WAYS-1:0]   hit_way;
  logic [WAYS-1:0]   valid_way;
  logic [WAYS-1:0]   dirty_way;
  logic [WAY_W-1:0]  way_sel;
  logic [BEAT_W-1:0] beat_idx;
  logic              cache_rd_en;
  logic              cache_wr_en;
  logic              refill_we;
  logic              victim_rd_en;
  logic              tag_update;
  logic              set_dirty;
  logic              mem_req;
  logic              mem_we;
  logic              mem_wt;
  logic              mem_gnt;
  logic              mem_beat;
  logic              resp_valid;
  logic              resp_hit;

  modport slave (
    input  req_valid, req_we,
    input  hit_way, valid_way, dirty_way,
    input  mem_gnt, mem_beat,
    output req_ready, tag_rd_en,
    output way_sel, beat_idx,
    output cache_rd_en, cache_wr_en,
    output refill_we, victim_rd_en,
    output tag_update, set_dirty,
    output mem_req, mem_we, mem_wt,
    output resp_valid, resp_hit
  );

  modport master (
    output req_valid, req_we,
    output hit_way, valid_way, dirty_way,
    output mem_gnt, mem_beat,
    input  req_ready, tag_rd_en,
    input  way_sel, beat_idx,
    input  cache_rd_en, cache_wr_en,
    input  refill_we, victim_rd_en,
    input  tag_update, set_dirty,
    input  mem_req, mem_we, mem_wt,
    input  resp_valid, resp_hit
  );

endinterface

// File: rtl/cache_victim_sel.sv
// Victim way choice: first invalid way, else round-robin pointer.
// The pointer only moves when a full set forces an eviction.
module cache_victim_sel
  import cache_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int WAY_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WAYS-1:0]  valid_way,
  input  logic             advance,
  output logic [WAY_W-1:0] victim,
  output logic             all_valid
);

  logic [WAY_W-1:0] rr_q, rr_d;

  // Pick the victim and compute the wrapped next pointer.
  always_comb begin
    all_valid = &valid_way;
    victim    = all_valid ? rr_q :
      WAY_W'(first_zero_idx(MAX_WAYS'(valid_way), WAYS));
    rr_d = rr_q;
    if (advance) begin
      rr_d = (rr_q == WAY_W'(WAYS - 1)) ? '0 :
             rr_q + WAY_W'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_q <= '0;
    else     rr_q <= rr_d;
  end

endmodule

// File: rtl/cache_ctrl_nway.sv
// N-way set-associative cache controller FSM.
// Sequences lookup, writeback, refill and write-through bursts.
module cache_ctrl_nway
  import cache_pkg::*;
#(
  parameter int WAYS         = 4,
  parameter int LINE_WORDS   = 4,
  parameter int WRITE_POLICY = 0
) (
  input  logic         clk,
  input  logic         rst,
  cache_ctrl_nway_if.slave bus
);

  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic IS_WT = (WRITE_POLICY == POLICY_WT);

  ctrl_state_t       state_q, state_d;
  logic [BEAT_W-1:0] cnt_q, cnt_d;
  logic [WAY_W-1:0]  way_q, way_d;
  logic              we_q, we_d;
  logic              hit_q, hit_d;

  logic              hit;
  logic              wt_wr;
  logic              last_beat;
  logic              advance;
  logic              all_valid;
  logic              vict_dirty;
  logic [WAY_W-1:0]  hit_idx;
  logic [WAY_W-1:0]  victim;

  assign hit       = |bus.hit_way;
  assign hit_idx   = WAY_W'(onehot_to_idx(MAX_WAYS'(bus.hit_way)));
  assign wt_wr     = IS_WT && we_q;
  assign last_beat = (cnt_q == BEAT_W'(LINE_WORDS - 1));
  assign advance   = (state_q == S_LOOKUP) && !hit &&
                     !wt_wr && all_valid;

  cache_victim_sel #(
    .WAYS  (WAYS),
    .WAY_W (WAY_W)
  ) u_victim (
    .clk       (clk),
    .rst       (rst),
    .valid_way (bus.valid_way),
    .advance   (advance),
    .victim    (victim),
    .all_valid (all_valid)
  );

  // Victim needs writeback only when it holds a valid dirty line.
  always_comb begin
    vict_dirty = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      if (victim == WAY_W'(i)) begin
        vict_dirty = bus.valid_way[i] & bus.dirty_way[i];
      end
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    way_d            = way_q;
    we_d             = we_q;
    hit_d            = hit_q;
    bus.req_ready    = 1'b0;
    bus.tag_rd_en    = 1'b0;
    bus.way_sel      = way_q;
    bus.beat_idx     = cnt_q;
    bus.cache_rd_en  = 1'b0;
    bus.cache_wr_en  = 1'b0;
    bus.refill_we    = 1'b0;
    bus.victim_rd_en = 1'b0;
    bus.tag_update   = 1'b0;
    bus.set_dirty    = 1'b0;
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_wt       = 1'b0;
    bus.resp_valid   = 1'b0;
    bus.resp_hit     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        bus.tag_rd_en = bus.req_valid;
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        hit_d = hit;
        if (hit) begin
          bus.way_sel = hit_idx;
          way_d       = hit_idx;
          if (!we_q) begin
            bus.cache_rd_en = 1'b1;
            bus.resp_valid  = 1'b1;
            bus.resp_hit    = 1'b1;
            state_d         = S_IDLE;
          end else if (IS_WT) begin
            bus.cache_wr_en = 1'b1;
            state_d         = S_WT_REQ;
          end else begin
            bus.cache_wr_en = 1'b1;
            bus.set_dirty   = 1'b1;
            bus.resp_valid  = 1'b1;
            bus.resp_hit    = 1'b1;
            state_d         = S_IDLE;
          end
        end else if (wt_wr) begin
          state_d = S_WT_REQ;
        end else begin
          bus.way_sel = victim;
          way_d       = victim;
          state_d     = (vict_dirty && !IS_WT) ?
                        S_WB_REQ : S_RF_REQ;
        end
      end
      S_WB_REQ: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = 1'b1;
        cnt_d       = '0;
        if (bus.mem_gnt) state_d = S_WB_DATA;
      end
      S_WB_DATA: begin
        bus.victim_rd_en = 1'b1;
        bus.mem_we       = 1'b1;
        if (bus.mem_beat) begin
          if (last_beat) begin
            cnt_d   = '0;
            state_d = S_RF_REQ;
          end else begin
            cnt_d = cnt_q + BEAT_W'(1);
          end
        end
      end
      S_RF_REQ: begin
        bus.mem_req = 1'b1;
        if (bus.mem_gnt) state_d = S_RF_DATA;
      end
      S_RF_DATA: begin
        if (bus.mem_beat) begin
          bus.refill_we = 1'b1;
          if (last_beat) begin
            bus.tag_update = 1'b1;
            bus.set_dirty  = we_q;
            cnt_d          = '0;
            state_d        = S_FINISH;
          end else begin
            cnt_d = cnt_q + BEAT_W'(1);
          end
        end
      end
      S_FINISH: begin
        bus.cache_rd_en = !we_q;
        bus.cache_wr_en = we_q;
        bus.set_dirty   = we_q;
        bus.resp_valid  = 1'b1;
        state_d         = S_IDLE;
      end
      S_WT_REQ: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = 1'b1;
        bus.mem_wt  = 1'b1;
        if (bus.mem_gnt) state_d = S_WT_DATA;
      end
      S_WT_DATA: begin
        bus.mem_we = 1'b1;
        bus.mem_wt = 1'b1;
        if (bus.mem_beat) begin
          bus.resp_valid = 1'b1;
          bus.resp_hit   = hit_q;
          state_d        = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      way_q   <= '0;
      we_q    <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      way_q   <= way_d;
      we_q    <= we_d;
      hit_q   <= hit_d;
    end
  end

endmodule

// File: tb/tb_cache_ctrl_nway.sv
// Directed bench for cache_ctrl_nway: WB 4x4, WT 4x4 and 1x1 builds.
// Expected values are hand-derived per step.
module tb_cache_ctrl_nway;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  cache_ctrl_nway_if #(.WAYS(4), .LINE_WORDS(4)) a_if ();
  cache_ctrl_nway_if #(.WAYS(4), .LINE_WORDS(4)) b_if ();
  cache_ctrl_nway_if #(.WAYS(1), .LINE_WORDS(1)) c_if ();

  cache_ctrl_nway #(
    .WAYS(4), .LINE_WORDS(4), .WRITE_POLICY(0)
  ) u_a (.clk(clk), .rst(rst), .bus(a_if.slave));

  cache_ctrl_nway #(
    .WAYS(4), .LINE_WORDS(4), .WRITE_POLICY(1)
  ) u_b (.clk(clk), .rst(rst), .bus(b_if.slave));

  cache_ctrl_nway #(
    .WAYS(1), .LINE_WORDS(1), .WRITE_POLICY(0)
  ) u_c (.clk(clk), .rst(rst), .bus(c_if.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Environment protocol sanity: one-hot hits, gnt only while requested.
  always @(negedge clk) begin
    if (!rst) begin
      chk("a_onehot", 32'($onehot0(a_if.hit_way)), 1);
      chk("b_onehot", 32'($onehot0(b_if.hit_way)), 1);
      chk("a_gnt", 32'(!a_if.mem_gnt || a_if.mem_req), 1);
      chk("b_gnt", 32'(!b_if.mem_gnt || b_if.mem_req), 1);
      chk("c_gnt", 32'(!c_if.mem_gnt || c_if.mem_req), 1);
    end
  end

  // Full miss on the WB 4x4 build, optionally with writeback.
  task automatic a_miss(
    input string    tag,
    input logic     we,
    input logic [3:0] valid,
    input logic [3:0] dirty,
    input int       exp_way,
    input bit       exp_wb
  );
    tick();
    a_if.req_valid = 1'b1;
    a_if.req_we    = we;
    #1;
    chk({tag, "/tag_rd"}, a_if.tag_rd_en, 1);
    tick();
    a_if.req_valid = 1'b0;
    a_if.hit_way   = 4'b0000;
    a_if.valid_way = valid;
    a_if.dirty_way = dirty;
    #1;
    chk({tag, "/victim"}, a_if.way_sel, exp_way);
    chk({tag, "/lk_resp"}, a_if.resp_valid, 0);
    tick();
    a_if.valid_way = 4'b0000;
    a_if.dirty_way = 4'b0000;
    if (exp_wb) begin
      #1;
      chk({tag, "/wb_req"}, a_if.mem_req, 1);
      chk({tag, "/wb_we"}, a_if.mem_we, 1);
      a_if.mem_gnt = 1'b1;
      tick();
      a_if.mem_gnt = 1'b0;
      for (int b = 0; b < 4; b++) begin
        a_if.mem_beat = 1'b1;
        #1;
        chk({tag, "/wb_rd"}, a_if.victim_rd_en, 1);
        chk({tag, "/wb_idx"}, a_if.beat_idx, b);
        chk({tag, "/wb_req0"}, a_if.mem_req, 0);
        tick();
      end
      a_if.mem_beat = 1'b0;
    end
    #1;
    chk({tag, "/rf_req"}, a_if.mem_req, 1);
    chk({tag, "/rf_we"}, a_if.mem_we, 0);
    a_if.mem_gnt = 1'b1;
    tick();
    a_if.mem_gnt = 1'b0;
    for (int b = 0; b < 4; b++) begin
      a_if.mem_beat = 1'b1;
      #1;
      chk({tag, "/rf_we"}, a_if.refill_we, 1);
      chk({tag, "/rf_idx"}, a_if.beat_idx, b);
      chk({tag, "/rf_way"}, a_if.way_sel, exp_way);
      chk({tag, "/tag_up"}, a_if.tag_update, (b == 3));
      if (b == 3) chk({tag, "/tag_dirty"}, a_if.set_dirty, we);
      tick();
    end
    a_if.mem_beat = 1'b0;
    #1;
    chk({tag, "/fin_resp"}, a_if.resp_valid, 1);
    chk({tag, "/fin_hit"}, a_if.resp_hit, 0);
    chk({tag, "/fin_rd"}, a_if.cache_rd_en, !we);
    chk({tag, "/fin_wr"}, a_if.cache_wr_en, we);
    chk({tag, "/fin_refill"}, a_if.refill_we, 0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    a_if.req_valid = 0; a_if.req_we = 0;
    a_if.hit_way = 0; a_if.valid_way = 0; a_if.dirty_way = 0;
    a_if.mem_gnt = 0; a_if.mem_beat = 0;
    b_if.req_valid = 0; b_if.req_we = 0;
    b_if.hit_way = 0; b_if.valid_way = 0; b_if.dirty_way = 0;
    b_if.mem_gnt = 0; b_if.mem_beat = 0;
    c_if.req_valid = 0; c_if.req_we = 0;
    c_if.hit_way = 0; c_if.valid_way = 0; c_if.dirty_way = 0;
    c_if.mem_gnt = 0; c_if.mem_beat = 0;

    #12;
    chk("rst_ready", a_if.req_ready, 1);
    chk("rst_mem_req", a_if.mem_req, 0);
    chk("rst_way", a_if.way_sel, 0);
    chk("rst_beat", a_if.beat_idx, 0);
    chk("rst_resp", a_if.resp_valid, 0);
    chk("rst_tag_rd", a_if.tag_rd_en, 0);
    rst = 1'b0;

    // Read hit on way 2.
    tick();
    a_if.req_valid = 1'b1;
    a_if.req_we    = 1'b0;
    #1;
    chk("rh_tag_rd", a_if.tag_rd_en, 1);
    tick();
    a_if.req_valid = 1'b0;
    a_if.hit_way   = 4'b0100;
    a_if.valid_way = 4'b1111;
    #1;
    chk("rh_rd", a_if.cache_rd_en, 1);
    chk("rh_way", a_if.way_sel, 2);
    chk("rh_resp", a_if.resp_valid, 1);
    chk("rh_hit", a_if.resp_hit, 1);
    chk("rh_ready", a_if.req_ready, 0);
    tick();
    a_if.hit_way   = 4'b0000;
    a_if.valid_way = 4'b0000;
    #1;
    chk("rh_idle", a_if.req_ready, 1);
    chk("rh_resp0", a_if.resp_valid, 0);

    // Write hit, write-back policy.
    a_if.req_valid = 1'b1;
    a_if.req_we    = 1'b1;
    tick();
    a_if.req_valid = 1'b0;
    a_if.hit_way   = 4'b0001;
    #1;
    chk("wh_wr", a_if.cache_wr_en, 1);
    chk("wh_dirty", a_if.set_dirty, 1);
    chk("wh_way", a_if.way_sel, 0);
    chk("wh_resp", a_if.resp_hit, 1);
    tick();
    a_if.hit_way = 4'b0000;
    #1;
    chk("wh_idle", a_if.req_ready, 1);

    // Read miss with an invalid way; pointer must stay at 0.
    a_miss("rmiss", 1'b0, 4'b1011, 4'b0000, 2, 1'b0);
    a_miss("rr0", 1'b0, 4'b1111, 4'b0000, 0, 1'b0);
    a_miss("rr1", 1'b0, 4'b1111, 4'b0000, 1, 1'b0);
    a_miss("rr2", 1'b0, 4'b1111, 4'b0000, 2, 1'b0);
    a_miss("wmiss", 1'b1, 4'b1111, 4'b1000, 3, 1'b1);
    a_miss("wrap", 1'b0, 4'b1111, 4'b0001, 0, 1'b1);

    // Reset on refill beat 2.
    tick();
    a_if.req_valid = 1'b1;
    a_if.req_we    = 1'b0;
    tick();
    a_if.req_valid = 1'b0;
    tick();
    a_if.mem_gnt = 1'b1;
    tick();
    a_if.mem_gnt  = 1'b0;
    a_if.mem_beat = 1'b1;
    tick();
    tick();
    #1;
    chk("rs_pre_refill", a_if.refill_we, 1);
    chk("rs_pre_idx", a_if.beat_idx, 2);
    rst = 1'b1;
    #1;
    chk("rs_refill", a_if.refill_we, 0);
    chk("rs_mem_req", a_if.mem_req, 0);
    chk("rs_ready", a_if.req_ready, 1);
    chk("rs_idx", a_if.beat_idx, 0);
    a_if.mem_beat = 1'b0;
    #1;
    rst = 1'b0;
    a_miss("after_rst", 1'b0, 4'b0000, 4'b0000, 0, 1'b0);
    tick();

    // Write-through: write miss, no allocate.
    b_if.req_valid = 1'b1;
    b_if.req_we    = 1'b1;
    tick();
    b_if.req_valid = 1'b0;
    b_if.valid_way = 4'b1111;
    #1;
    chk("wtm_tag_up", b_if.tag_update, 0);
    chk("wtm_wr", b_if.cache_wr_en, 0);
    chk("wtm_resp0", b_if.resp_valid, 0);
    tick();
    b_if.valid_way = 4'b0000;
    #1;
    chk("wtm_req", b_if.mem_req, 1);
    chk("wtm_we", b_if.mem_we, 1);
    chk("wtm_wt", b_if.mem_wt, 1);
    b_if.mem_gnt = 1'b1;
    tick();
    b_if.mem_gnt = 1'b0;
    #1;
    chk("wtm_req0", b_if.mem_req, 0);
    chk("wtm_wait", b_if.resp_valid, 0);
    b_if.mem_beat = 1'b1;
    #1;
    chk("wtm_resp", b_if.resp_valid, 1);
    chk("wtm_hit", b_if.resp_hit, 0);
    chk("wtm_refill", b_if.refill_we, 0);
    tick();
    b_if.mem_beat = 1'b0;
    #1;
    chk("wtm_idle", b_if.req_ready, 1);

    // Write-through: write hit on way 1.
    b_if.req_valid = 1'b1;
    b_if.req_we    = 1'b1;
    tick();
    b_if.req_valid = 1'b0;
    b_if.hit_way   = 4'b0010;
    #1;
    chk("wth_wr", b_if.cache_wr_en, 1);
    chk("wth_dirty", b_if.set_dirty, 0);
    chk("wth_way", b_if.way_sel, 1);
    chk("wth_resp0", b_if.resp_valid, 0);
    tick();
    b_if.hit_way = 4'b0000;
    #1;
    chk("wth_wt", b_if.mem_wt, 1);
    b_if.mem_gnt = 1'b1;
    tick();
    b_if.mem_gnt  = 1'b0;
    b_if.mem_beat = 1'b1;
    #1;
    chk("wth_resp", b_if.resp_valid, 1);
    chk("wth_hit", b_if.resp_hit, 1);
    tick();
    b_if.mem_beat = 1'b0;

    // One way, one word: gnt with a same-cycle beat.
    c_if.req_valid = 1'b1;
    c_if.req_we    = 1'b0;
    tick();
    c_if.req_valid = 1'b0;
    c_if.valid_way = 1'b1;
    #1;
    chk("c_way", c_if.way_sel, 0);
    tick();
    c_if.valid_way = 1'b0;
    c_if.mem_gnt   = 1'b1;
    c_if.mem_beat  = 1'b1;
    #1;
    chk("c_req", c_if.mem_req, 1);
    chk("c_gnt_refill", c_if.refill_we, 0);
    tick();
    c_if.mem_gnt  = 1'b0;
    c_if.mem_beat = 1'b0;
    #1;
    chk("c_wait_refill", c_if.refill_we, 0);
    chk("c_wait_resp", c_if.resp_valid, 0);
    tick();
    c_if.mem_beat = 1'b1;
    #1;
    chk("c_refill", c_if.refill_we, 1);
    chk("c_tag_up", c_if.tag_update, 1);
    chk("c_idx", c_if.beat_idx, 0);
    tick();
    c_if.mem_beat = 1'b0;
    #1;
    chk("c_resp", c_if.resp_valid, 1);
    chk("c_hit", c_if.resp_hit, 0);
    chk("c_rd", c_if.cache_rd_en, 1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
